// File: rtl/mem_arb_pkg.sv
// Shared state encoding and parameter defaults for the two-master memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF    = 14;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_W       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not own the port last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner
);

    // Winner select from the request pair and previous owner
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port memory controller: registered grants,
// burst-limited ownership with zero-gap hand-over and one-cycle read return.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_ctrl_we,
    output logic [ADDR_W-1:0] mem_ctrl_addr,
    output logic [DATA_W-1:0] mem_ctrl_in,
    input  logic [DATA_W-1:0] mem_ctrl_out
);

    arb_state_e         state_q;
    logic               last_owner_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic               m0_rvalid_q;
    logic               m1_rvalid_q;
    logic               issue0_s;
    logic               issue1_s;
    logic               at_max_s;
    logic               winner_s;

    assign issue0_s = (state_q == OWN0) && m0_req;
    assign issue1_s = (state_q == OWN1) && m1_req;
    assign burst_d  = burst_q + {{(BURST_W-1){1'b0}}, 1'b1};
    assign at_max_s = (burst_d == BURST_W'(MAX_BURST));

    rr_arb2 u_rr_arb2 (
        .req        ({m1_req, m0_req}),
        .last_owner (last_owner_q),
        .winner     (winner_s)
    );

    // Ownership FSM, burst counter, last-owner memory and read-valid tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_q      <= {BURST_W{1'b0}};
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
        end else begin
            m0_rvalid_q <= issue0_s && !m0_we;
            m1_rvalid_q <= issue1_s && !m1_we;
            case (state_q)
                IDLE: begin
                    burst_q <= {BURST_W{1'b0}};
                    if (m0_req || m1_req) begin
                        state_q <= own_state(winner_s);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN0: begin
                    if (!m0_req) begin
                        burst_q      <= {BURST_W{1'b0}};
                        last_owner_q <= 1'b0;
                        state_q      <= m1_req ? OWN1 : IDLE;
                    end else if (at_max_s) begin
                        // Burst limit: yield only if the other side is waiting
                        burst_q <= {BURST_W{1'b0}};
                        if (m1_req) begin
                            state_q      <= OWN1;
                            last_owner_q <= 1'b0;
                        end else begin
                            state_q <= OWN0;
                        end
                    end else begin
                        burst_q <= burst_d;
                        state_q <= OWN0;
                    end
                end
                OWN1: begin
                    if (!m1_req) begin
                        burst_q      <= {BURST_W{1'b0}};
                        last_owner_q <= 1'b1;
                        state_q      <= m0_req ? OWN0 : IDLE;
                    end else if (at_max_s) begin
                        burst_q <= {BURST_W{1'b0}};
                        if (m0_req) begin
                            state_q      <= OWN0;
                            last_owner_q <= 1'b1;
                        end else begin
                            state_q <= OWN1;
                        end
                    end else begin
                        burst_q <= burst_d;
                        state_q <= OWN1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    burst_q <= {BURST_W{1'b0}};
                end
            endcase
        end
    end

    // Memory-port mux: only the owning, requesting master reaches the controller
    always_comb begin
        mem_ctrl_we   = 1'b0;
        mem_ctrl_addr = {ADDR_W{1'b0}};
        mem_ctrl_in   = {DATA_W{1'b0}};
        if (issue0_s) begin
            mem_ctrl_we   = m0_we;
            mem_ctrl_addr = m0_addr;
            mem_ctrl_in   = m0_wdata;
        end else if (issue1_s) begin
            mem_ctrl_we   = m1_we;
            mem_ctrl_addr = m1_addr;
            mem_ctrl_in   = m1_wdata;
        end else begin
            mem_ctrl_we   = 1'b0;
            mem_ctrl_addr = {ADDR_W{1'b0}};
            mem_ctrl_in   = {DATA_W{1'b0}};
        end
    end

    assign m0_gnt    = (state_q == OWN0);
    assign m1_gnt    = (state_q == OWN1);
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = mem_ctrl_out;
    assign m1_rdata  = mem_ctrl_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small one-cycle-latency memory model.
module tb_mem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_ctrl_we;
    logic [ADDR_W-1:0] mem_ctrl_addr;
    logic [DATA_W-1:0] mem_ctrl_in;
    logic [DATA_W-1:0] mem_ctrl_out;

    logic [DATA_W-1:0] mem_q [0:1023];

    int n_vec = 0;
    int n_err = 0;
    int rv_cnt;

    mem_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_gnt        (m0_gnt),
        .m0_rvalid     (m0_rvalid),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_gnt        (m1_gnt),
        .m1_rvalid     (m1_rvalid),
        .m1_rdata      (m1_rdata),
        .mem_ctrl_we   (mem_ctrl_we),
        .mem_ctrl_addr (mem_ctrl_addr),
        .mem_ctrl_in   (mem_ctrl_in),
        .mem_ctrl_out  (mem_ctrl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory controller stand-in: write on the edge, read data one cycle later
    always @(posedge clk) begin
        if (mem_ctrl_we) mem_q[mem_ctrl_addr[9:0]] <= mem_ctrl_in;
        mem_ctrl_out <= mem_q[mem_ctrl_addr[9:0]];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 14'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 14'h0; m1_wdata = 32'h0;
        #3;
        check_val("reset_gnt",    {m0_gnt, m1_gnt}, 2'b00);
        check_val("reset_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        check_val("reset_ctrl",   {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 47'h0);
        tick(); tick();
        rst = 1'b1;

        // Tie from reset: master 0 wins, grant appears a cycle later
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 14'h0010; m0_wdata = 32'hDEADBEEF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0010; m1_wdata = 32'h0;
        #2;
        check_val("tie_no_comb_gnt", {m0_gnt, m1_gnt}, 2'b00);
        check_val("idle_ctrl_zero", {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 47'h0);

        tick(); #2;
        check_val("b1_gnt",  {m0_gnt, m1_gnt}, 2'b10);
        check_val("b1_we",   mem_ctrl_we, 1'b1);
        check_val("b1_addr", mem_ctrl_addr, 14'h0010);
        check_val("b1_in",   mem_ctrl_in, 32'hDEADBEEF);

        tick();
        m0_we = 1'b0; m0_wdata = 32'h11111111;
        #2;
        check_val("b2_ctrl",   {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, {1'b0, 14'h0010, 32'h11111111});
        check_val("b2_rvalid0", m0_rvalid, 1'b0);

        tick();
        m0_we = 1'b1; m0_addr = 14'h0020; m0_wdata = 32'hCAFEF00D;
        #2;
        check_val("b3_rvalid0", m0_rvalid, 1'b1);
        check_val("b3_rdata0",  m0_rdata, 32'hDEADBEEF);
        check_val("b3_rvalid1", m1_rvalid, 1'b0);
        check_val("b3_gnt",     {m0_gnt, m1_gnt}, 2'b10);

        tick();
        m0_we = 1'b0;
        #2;
        check_val("b4_gnt",     {m0_gnt, m1_gnt}, 2'b10);
        check_val("b4_ctrl",    {mem_ctrl_we, mem_ctrl_addr}, {1'b0, 14'h0020});

        // m0 still requesting: hand-over here comes from the burst limit
        tick(); #2;
        check_val("handover_gnt",     {m0_gnt, m1_gnt}, 2'b01);
        check_val("handover_rvalid0", m0_rvalid, 1'b1);
        check_val("handover_rdata0",  m0_rdata, 32'hCAFEF00D);
        check_val("handover_rvalid1", m1_rvalid, 1'b0);
        check_val("handover_ctrl",    {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, {1'b0, 14'h0010, 32'h0});

        tick();
        m1_req = 1'b0;
        #2;
        check_val("m1_drop_gnt",    {m0_gnt, m1_gnt}, 2'b01);
        check_val("m1_drop_rvalid", m1_rvalid, 1'b1);
        check_val("m1_drop_rdata",  m1_rdata, 32'hDEADBEEF);
        check_val("m1_drop_ctrl",   {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 47'h0);

        tick();
        m0_req = 1'b0;
        #2;
        check_val("back_to_m0_gnt",  {m0_gnt, m1_gnt}, 2'b10);
        check_val("back_to_m0_ctrl", {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 47'h0);

        tick();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0010;
        #2;
        check_val("idle_gnt", {m0_gnt, m1_gnt}, 2'b00);

        // m1 alone: 10 back-to-back reads, alternating the two written words
        rv_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 10) m1_addr = (i % 2 == 1) ? 14'h0020 : 14'h0010;
            else m1_req = 1'b0;
            #2;
            if (i < 10) check_val("solo_gnt", {m0_gnt, m1_gnt}, 2'b01);
            if (m1_rvalid) begin
                check_val("solo_rdata", m1_rdata, (rv_cnt % 2 == 1) ? 32'hCAFEF00D : 32'hDEADBEEF);
                rv_cnt++;
            end
        end
        check_val("solo_rvalid_count", rv_cnt, 10);

        // m0 owns then yields so that last_owner becomes 0 before the reset
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0010;
        tick(); #2;
        check_val("pre_rst_m0_gnt", {m0_gnt, m1_gnt}, 2'b10);
        tick();
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 14'h0010;
        tick(); #2;
        check_val("pre_rst_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
        tick();
        m1_addr = 14'h0020;
        #2;
        check_val("pre_rst_rvalid1", m1_rvalid, 1'b1);
        check_val("pre_rst_rdata1",  m1_rdata, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        check_val("rst_async_rvalid1", m1_rvalid, 1'b0);
        check_val("rst_async_gnt",     {m0_gnt, m1_gnt}, 2'b00);
        check_val("rst_async_ctrl",    {mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 47'h0);
        tick(); #2;
        check_val("rst_pending_dropped", m1_rvalid, 1'b0);
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 14'h0020;
        tick(); #2;
        check_val("post_rst_tie_gnt", {m0_gnt, m1_gnt}, 2'b10);

        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_we = 1'b1; m0_addr = 14'h3FFF; m0_wdata = 32'hFFFFFFFF;
        m1_we = 1'b1; m1_addr = 14'h2AAA; m1_wdata = 32'h55555555;

        // Quiet bus with busy-looking master inputs
        for (int i = 0; i < 20; i++) begin
            tick(); #2;
            check_val("idle_quiet", {m0_gnt, m1_gnt, mem_ctrl_we, mem_ctrl_addr, mem_ctrl_in}, 49'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 14, word address width; DATA_W, 32, data width; MAX_BURST, 4, maximum consecutive transfers before a forced hand-over when the other master is requesting.
REQ-002 clk  in  1  single system clock, all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 m0_req  in  1  master 0 requests ownership and a transfer.
REQ-005 m0_we  in  1  master 0 write enable, 1 = write, 0 = read.
REQ-006 m0_addr  in  ADDR_W  master 0 word address.
REQ-007 m0_wdata  in  DATA_W  master 0 write data.
REQ-008 m0_gnt  out  1  master 0 owns the memory port this cycle.
REQ-009 m0_rvalid  out  1  m0_rdata holds read data for the previous-cycle master 0 read.
REQ-010 m0_rdata  out  DATA_W  read data to master 0.
REQ-011 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata SHALL mirror REQ-004..010 for master 1.
REQ-012 mem_ctrl_we  out  1  write enable to memory_controller.
REQ-013 mem_ctrl_addr  out  ADDR_W  address to memory_controller.
REQ-014 mem_ctrl_in  out  DATA_W  write data to memory_controller.
REQ-015 mem_ctrl_out  in  DATA_W  read data from memory_controller, valid one cycle after the address.

Function
REQ-016 FSM states SHALL be IDLE, OWN0 and OWN1; mN_gnt = 1 exactly when state is OWNN (registered, no combinational req-to-gnt path).
REQ-017 IDLE with exactly one mN_req = 1 SHALL go to OWNN; with both requesting it SHALL go to the master that is not last_owner; with neither requesting it SHALL stay IDLE.
REQ-018 A transfer SHALL be issued in every cycle where state = OWNN and mN_req = 1; mem_ctrl_we/addr/in then equal mN_we/addr/wdata, driven combinationally.
REQ-019 In all other cycles mem_ctrl_we, mem_ctrl_addr and mem_ctrl_in SHALL be 0.
REQ-020 Read latency SHALL be 1 cycle: mN_rvalid is registered as (state = OWNN and mN_req and not mN_we), so a read issued in cycle t has mN_rvalid = 1 in cycle t+1.
REQ-021 m0_rdata and m1_rdata SHALL both equal mem_ctrl_out; only rvalid qualifies them.
REQ-022 A 3-bit burst counter SHALL increment per issued transfer and clear on every state change.
REQ-023 In OWNN, if the counter reaches MAX_BURST and the other master requests, next state SHALL be the other OWN state; if the other master is not requesting, the counter SHALL clear and ownership is kept.
REQ-024 In OWNN with mN_req = 0, no transfer is issued; next state SHALL be the other OWN state if the other master requests, else IDLE.
REQ-025 last_owner SHALL update to N whenever OWNN is exited.
REQ-026 A read issued in the last cycle before a hand-over SHALL still produce mN_rvalid on the following cycle, concurrent with the new owner's first transfer; no transfer is lost or duplicated.
REQ-027 Hand-over between owners SHALL take 0 idle cycles (OWN0 to OWN1 directly).
REQ-028 A master SHALL hold req, we, addr and wdata stable until its gnt is sampled high.

Reset
REQ-029 When rst = 0: state = IDLE, m0_gnt = m1_gnt = 0, m0_rvalid = m1_rvalid = 0, burst counter = 0, last_owner = 1 (master 0 wins the first tie), and all mem_ctrl outputs = 0, immediately and asynchronously.
REQ-030 Reset asserted mid-burst SHALL drop the transfer in flight, including a pending rvalid; operation restarts from IDLE on the first rising edge after rst = 1.

Structure
REQ-031 A shared package mem_arb_pkg SHALL hold the state enumeration (IDLE, OWN0, OWN1) and the ADDR_W/DATA_W defaults.
REQ-032 The two-way round-robin pick SHALL be a sub-module rr_arb2 (inputs req[1:0], last_owner; output winner); all other logic stays in mem_arbiter.

Verification
REQ-033 Reset, then m0_req = 1 and m1_req = 1 in the same cycle -> m0_gnt = 1 in the next cycle; after 4 transfers, m1_gnt = 1 in the cycle after.
REQ-034 Master 0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 -> mem_ctrl_we = 1 with addr 0x0010 during the write cycle; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF one cycle after the read.
REQ-035 m1 alone holds req for 10 reads -> m1_gnt stays 1 throughout with no gap, and 10 m1_rvalid pulses arrive.
REQ-036 m0 issues a read in its 4th burst cycle while m1 waits -> m0_rvalid = 1 and m1_gnt = 1 in the same next cycle; m1_rvalid = 0 in that cycle.
REQ-037 rst pulsed low for 1 cycle during an OWN1 read -> m1_rvalid = 0, gnt = 0 and mem_ctrl_* = 0 immediately; the next tie goes to master 0.
REQ-038 No requests for 20 cycles -> state stays IDLE and mem_ctrl_we, mem_ctrl_addr and mem_ctrl_in stay 0.
